// File: rtl/mul_reduce_seq.sv
// Sequential pairwise reduction of N W-bit partial products through one shared adder.
// Operands load into a register buffer and are then folded level by level in binary-tree order.
module mul_reduce_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         pp_valid,
  input  logic [W-1:0] pp_data,
  output logic         pp_ready,
  output logic         busy,
  output logic         sum_valid,
  output logic [W-1:0] sum,
  input  logic         sum_ready
);

  localparam int unsigned LG = $clog2(N);

  localparam logic [LG:0]   CNT_ONE  = (LG+1)'(1);
  localparam logic [LG:0]   CNT_LAST = (LG+1)'(N - 1);
  localparam logic [LG:0]   M_FULL   = (LG+1)'(N);
  localparam logic [LG-1:0] K_ONE    = LG'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [LG:0]   cnt_q, cnt_d;
  logic [LG:0]   m_q, m_d;
  logic [LG-1:0] k_q, k_d;
  logic [W-1:0]  buf_q [N];

  logic          wr_en;
  logic [LG-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic [LG-1:0] idx_a, idx_b;
  logic [W-1:0]  add_sum;
  logic [LG:0]   half_m;

  // Pair (2k, 2k+1); truncating {k,0} keeps 2k in range since k < m/2 <= N/2.
  assign idx_a   = LG'({k_q, 1'b0});
  assign idx_b   = idx_a | K_ONE;
  assign add_sum = buf_q[idx_a] + buf_q[idx_b];
  assign half_m  = m_q >> 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    k_d     = k_q;
    wr_en   = 1'b0;
    wr_idx  = k_q;
    wr_data = add_sum;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (pp_valid) begin
          wr_en   = 1'b1;
          wr_idx  = cnt_q[LG-1:0];
          wr_data = pp_data;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = REDUCE;
            m_d     = M_FULL;
            k_d     = '0;
          end
        end
      end
      REDUCE: begin
        wr_en = 1'b1;
        if ({1'b0, k_q} == half_m - CNT_ONE) begin
          m_d = half_m;
          k_d = '0;
          if (half_m == CNT_ONE) state_d = DONE;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      DONE: begin
        if (sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

  assign pp_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign sum_valid = (state_q == DONE);
  assign sum       = sum_valid ? buf_q[0] : '0;

endmodule

// File: tb/tb_mul_reduce_seq.sv
// Scoreboard bench for mul_reduce_seq: an N=8 and an N=2 instance share one clock and reset.
module tb_mul_reduce_seq;

  localparam int unsigned W = 128;

  logic clk;
  logic rst_n;

  logic         start8, pp_valid8, pp_ready8, busy8, sum_valid8, sum_ready8;
  logic [W-1:0] pp_data8, sum8;
  logic         start2, pp_valid2, pp_ready2, busy2, sum_valid2, sum_ready2;
  logic [W-1:0] pp_data2, sum2;

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  int unsigned  bc8   = 0;
  logic [W-1:0] q8 [$];
  logic [W-1:0] q2 [$];

  mul_reduce_seq #(.N(8), .W(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .pp_valid(pp_valid8), .pp_data(pp_data8),
    .pp_ready(pp_ready8), .busy(busy8), .sum_valid(sum_valid8), .sum(sum8), .sum_ready(sum_ready8)
  );

  mul_reduce_seq #(.N(2), .W(W)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pp_valid(pp_valid2), .pp_data(pp_data2),
    .pp_ready(pp_ready2), .busy(busy2), .sum_valid(sum_valid2), .sum(sum2), .sum_ready(sum_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare on every result handshake; also count busy cycles of the N=8 unit.
  always @(negedge clk) begin
    if (busy8) bc8++;
    if (sum_valid8 && sum_ready8) begin
      chk("sb8_pending", W'(q8.size() != 0), W'(1));
      if (q8.size() != 0) chk("sb8_sum", sum8, q8.pop_front());
    end
    if (sum_valid2 && sum_ready2) begin
      chk("sb2_pending", W'(q2.size() != 0), W'(1));
      if (q2.size() != 0) chk("sb2_sum", sum2, q2.pop_front());
    end
  end

  // One full N=8 operation: gap = max stall cycles between operands, hold = cycles of
  // sum_ready low in DONE, noise = keep start high while the unit is busy.
  task automatic run8(input logic [W-1:0] ops [8], input int unsigned gap,
                      input int unsigned hold, input bit noise, input bit chk_busy);
    logic [W-1:0] acc;
    int unsigned  n;
    acc = '0;
    bc8 = 0;
    start8 = 1'b1;
    step();
    start8 = noise;
    chk("load_ready", W'(pp_ready8), W'(1));
    for (int i = 0; i < 8; i++) begin
      pp_valid8 = 1'b0;
      repeat (gap == 0 ? 0 : $urandom_range(gap, 0)) step();
      pp_valid8 = 1'b1;
      pp_data8  = ops[i];
      acc = acc + ops[i];
      step();
    end
    pp_valid8 = 1'b0;
    q8.push_back(acc);
    sum_ready8 = (hold == 0);
    n = 0;
    while (!sum_valid8 && n < 40) begin
      step();
      n++;
    end
    chk("latency8", W'(n), W'(7));
    for (int unsigned h = 0; h < hold; h++) begin
      chk("hold_valid", W'(sum_valid8), W'(1));
      chk("hold_sum", sum8, acc);
      step();
    end
    sum_ready8 = 1'b1;
    step();
    start8 = 1'b0;
    sum_ready8 = 1'b0;
    chk("back_idle_busy", W'(busy8), W'(0));
    chk("back_idle_valid", W'(sum_valid8), W'(0));
    if (chk_busy) chk("busy_cycles", W'(bc8), W'(16));
    step();
  endtask

  logic [W-1:0] ops [8];
  int unsigned  n2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; pp_valid8 = 1'b1; pp_data8 = '1; sum_ready8 = 1'b0;
    start2 = 1'b0; pp_valid2 = 1'b1; pp_data2 = '1; sum_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", W'(pp_ready8), W'(0));
    chk("rst_busy", W'(busy8), W'(0));
    chk("rst_valid", W'(sum_valid8), W'(0));
    chk("rst_sum", sum8, '0);
    chk("rst_ready2", W'(pp_ready2), W'(0));
    rst_n = 1'b1;
    step();
    chk("idle_no_hs", W'(pp_ready8), W'(0));
    chk("idle_busy", W'(busy8), W'(0));
    pp_valid8 = 1'b0;
    pp_valid2 = 1'b0;
    step();

    for (int i = 0; i < 8; i++) ops[i] = W'(i + 1);
    run8(ops, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) ops[i] = {1'b1, {(W-1){1'b0}}};
    run8(ops, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) ops[i] = '0;
    ops[0] = '1;
    ops[1] = W'(1);
    run8(ops, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) ops[i] = W'(10 * (i + 1));
    run8(ops, 3, 5, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) ops[i] = W'(3 * i + 100);
    run8(ops, 1, 2, 1'b1, 1'b0);

    // Abort after four operands, then a fresh operation must see none of them.
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pp_valid8 = 1'b1;
      pp_data8  = W'(1000 + i);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy8), W'(0));
    chk("abort_ready", W'(pp_ready8), W'(0));
    pp_valid8 = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) ops[i] = W'(i + 1);
    run8(ops, 0, 0, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) ops[i] = {$urandom, $urandom, $urandom, $urandom};
      run8(ops, 2, $urandom_range(3, 0), 1'b0, 1'b0);
    end

    // N=2 instance: one REDUCE cycle.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("n2_ready", W'(pp_ready2), W'(1));
    pp_valid2 = 1'b1;
    pp_data2  = W'(5);
    step();
    pp_data2  = W'(7);
    step();
    pp_valid2 = 1'b0;
    q2.push_back(W'(12));
    sum_ready2 = 1'b1;
    n2 = 0;
    while (!sum_valid2 && n2 < 20) begin
      chk("n2_reduce_busy", W'(busy2), W'(1));
      step();
      n2++;
    end
    chk("n2_latency", W'(n2), W'(1));
    step();
    chk("n2_idle", W'(busy2), W'(0));
    sum_ready2 = 1'b0;

    repeat (3) step();
    chk("sb8_drained", W'(q8.size()), W'(0));
    chk("sb2_drained", W'(q2.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_reduce_seq.md
# mul_reduce_seq

Sequential reduction controller for the multiplier's partial-product path. Instead of instantiating a full N-input combinational adder tree, it buffers N 128-bit partial products and folds them pairwise through one shared 128-bit adder, level by level, with the same pairing order as a binary tree. It sits between the partial-product generator (producer, valid/ready) and the multiplier result register (consumer, valid/ready). It trades latency for area.

## Interface
- `N`, default 8: number of partial products per operation. Must be a power of 2 and at least 2.
- `W`, default 128: operand and sum width.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begins an operation; honoured only in IDLE.
- `pp_valid`  input  1  producer has a partial product on `pp_data`.
- `pp_data`  input  W  partial product.
- `pp_ready`  output  1  block accepts `pp_data` this cycle.
- `busy`  output  1  high in every state except IDLE.
- `sum_valid`  output  1  `sum` holds the final result.
- `sum`  output  W  reduced result.
- `sum_ready`  input  1  consumer accepts `sum`.

## Operation
- Storage:
  - Register buffer `buf[0..N-1]`, each W bits.
  - Load counter `cnt`, log2(N)+1 bits.
  - Level size `m` and pair index `k`.
- States and transitions:
  - IDLE: `pp_ready`=0, `busy`=0, `sum_valid`=0. `start`=1 moves to LOAD and clears `cnt` to 0.
  - LOAD: `pp_ready`=1.
    - On each `pp_valid && pp_ready`: write `buf[cnt]` ← `pp_data`, then `cnt`++.
    - When the N-th operand is accepted, move to REDUCE with `m`=N and `k`=0.
    - A cycle with `pp_valid`=0 is a stall: nothing changes.
  - REDUCE: `pp_ready`=0. Each cycle: `buf[k]` ← `buf[2k]` + `buf[2k+1]`, then `k`++.
    - When `k` = m/2−1: set `m` ← m/2 and `k` ← 0.
    - When `m` reaches 1: move to DONE.
    - Exactly one addition per cycle, through a single adder instance.
  - DONE: `sum_valid`=1 and `sum`=`buf[0]`.
    - On `sum_ready`=1: move to IDLE.
    - While `sum_ready`=0, hold `sum` and `sum_valid` stable.
- Arithmetic:
  - Addition is unsigned modulo 2^W; carry-out is discarded.
  - Pairing order is fixed as (0,1),(2,3),… at each level.
  - The result equals the sum of all N operands mod 2^W.
- Ignored inputs:
  - `start` is ignored in LOAD, REDUCE and DONE; no restart and no queuing.
  - `pp_valid` is ignored outside LOAD.
  - `sum_ready` is ignored outside DONE.
- Reset (`rst_n`=0, asynchronous) at any time, including mid-LOAD or mid-REDUCE:
  - State goes to IDLE.
  - `cnt`, `m`, `k` go to 0.
  - All `buf` entries go to 0.
  - Outputs: `pp_ready`=0, `busy`=0, `sum_valid`=0, `sum`=0.
  - A partially loaded operation is discarded.
- Outputs `pp_ready`, `busy` and `sum_valid` are decoded from the registered state only. No combinational path from any input to any output.

## Timing
- `start` sampled at edge t0: `pp_ready`=1 from cycle t0+1.
- Last operand accepted at edge tL:
  - REDUCE occupies cycles tL+1 … tL+N−1, which is N−1 additions (N=8 gives 7).
  - `sum_valid` rises in cycle tL+N.
- Minimum operation length with no stalls and immediate `sum_ready`: 1 + N + (N−1) + 1 = 2N+1 cycles from `start` to return to IDLE.
- The same-cycle `start` that leaves DONE is ignored. A new `start` is accepted one cycle after returning to IDLE, so there is no overlap of operations.
- `pp_valid` may toggle arbitrarily. The number of accepted operands always equals the number of LOAD-cycle handshakes.
- Reset deassertion: first state change possible on the first rising edge after `rst_n` goes high.

## Test plan
- Reset values: hold `rst_n`=0 over 3 edges, then release. All outputs are 0 and state is IDLE; `pp_valid`=1 gives no handshake.
- Basic N=8:
  - Stimulus: `start`, then operands 1..8 back-to-back, with `sum_ready`=1.
  - Response: `sum`=36. `sum_valid` appears exactly 8 cycles after the last accept and lasts 1 cycle. `busy` is high for 16 cycles.
- Wrap-around:
  - Stimulus: all 8 operands = 2^127.
  - Response: `sum`=0.
  - Stimulus: operands 2^128−1 and 1, rest 0.
  - Response: `sum`=0.
- Stalls and backpressure:
  - Stimulus: operands 10,20,…,80 with `pp_valid` gaps of 0–3 cycles, and `sum_ready` held low for 5 cycles.
  - Response: `sum`=360, held stable with `sum_valid`=1 for all 5 cycles. IDLE is entered the cycle after `sum_ready`=1.
- Ignored start and mid-operation reset:
  - Pulse `start` during LOAD and REDUCE: no effect on the result.
  - Drop `rst_n` after 4 operands: IDLE immediately. A fresh operation with operands 1..8 then yields 36, with no stale data.
- N=2 instance:
  - Stimulus: operands 5 and 7.
  - Response: `sum`=12. REDUCE lasts exactly 1 cycle and `sum_valid` appears 2 cycles after the last accept.
